mux_serializer: RTL and testbench
=================================

# mux_serializer

Frame transmitter that sits directly upstream of a serial line and drives the select input of an 8:1 mux to emit a parallel byte bit by bit. It accepts one byte per valid/ready handshake, wraps it in a start bit, optional parity and a stop bit, and holds each bit for a programmable number of clocks. The output is registered and glitch-free, so it can drive a pad or a downstream deserializer directly.

## Interface
- CLKS_PER_BIT, 4: clocks per transmitted bit; legal range 1..255.
- PARITY_EN, 0: 1 inserts a parity bit between the last data bit and the stop bit.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.

- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- load_data  input  8  byte to transmit; sampled only on acceptance.
- load_valid  input  1  upstream has a byte.
- load_ready  output  1  block can accept a byte; high only in IDLE.
- tx_out  output  1  registered serial line; idle level 1.
- busy  output  1  high from the acceptance edge until the end of the stop bit.
- done  output  1  one-cycle pulse when the stop bit completes.

## Operation
- Reset values: tx_out=1, load_ready=1, busy=0, done=0, state=IDLE. The byte register, bit counter and clock divider are all 0.
- Acceptance: load_valid && load_ready at a rising edge. On that edge:
  - load_data is copied into the byte register.
  - The state moves to START and tx_out goes to 0.
- States: IDLE -> START -> DATA (8 bits) -> PARITY (only if PARITY_EN) -> STOP -> IDLE.
- Each non-IDLE state, and each DATA bit, lasts exactly CLKS_PER_BIT cycles, timed by a divider that counts 0..CLKS_PER_BIT-1.
- DATA order:
  - Data goes out MSB-first. Bit index k=0..7 drives the mux select.
  - The eightbitmux maps select k to in[7-k], so tx_out carries byte[7-k] during bit k.
  - tx_out is loaded from the mux output on the edge that enters each bit.
- PARITY bit: ^byte for even parity, ~^byte for odd parity.
- STOP bit: tx_out=1.
- End of frame: on the edge ending STOP, the state returns to IDLE, done=1 for one cycle, and load_ready=1.
- While busy: load_valid is ignored and nothing is queued. Upstream must hold its byte until load_ready.
- Changes on load_data after acceptance have no effect on the frame in progress.
- Reset mid-frame: tx_out returns to 1 asynchronously and the frame is abandoned. There is no done pulse, and the first acceptance after reset deasserts starts a fresh frame.

## Timing
- Frame length: (10 + PARITY_EN) × CLKS_PER_BIT cycles, measured from the acceptance edge E0 to the done edge.
- Transition edges: tx_out changes only at edges E0 + n×CLKS_PER_BIT.
- Back-to-back frames: the minimum gap is one IDLE cycle at tx_out=1. Acceptance is at the done edge +1 when load_valid is held high.
- CLKS_PER_BIT=1: one bit per cycle with no divider wait states.
- done and load_ready rise on the same edge. busy falls on that edge.

## Structure
- Shared header serial_defs.vh holds:
  - the state encodings (IDLE, START, DATA, PARITY, STOP);
  - the data bit count (8);
  - the stop level (1).
- One sub-module: eightbitmux, with in=byte register and s=bit counter[2:0]. Its output feeds the tx_out register during DATA.
- All other logic (FSM, divider, parity) is inline.

## Test plan
- Basic frame, CLKS_PER_BIT=4, PARITY_EN=0, load 8'hA5 accepted at E0:
  - tx_out is 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles.
  - done pulses at E0+40.
- Parity: load 8'hA5 with PARITY_EN=1.
  - PARITY_ODD=0 gives a parity bit of 0 at E0+36..E0+39, and done at E0+44.
  - PARITY_ODD=1 gives a parity bit of 1.
- Back-to-back: hold load_valid=1 with 8'h3C then 8'hC3.
  - The second byte is accepted at E0+41, and tx_out=1 during cycle E0+40.
  - The second frame is 0, 1,1,0,0,0,0,1,1, 1.
- Ignore while busy: pulse load_valid with 8'h00 during DATA of an 8'hFF frame.
  - All 8 data bits stay 1.
  - load_ready stays 0, and there is no second frame.
- Reset mid-frame: assert reset at E0+17 between edges.
  - tx_out=1, busy=0, load_ready=1 and done=0 immediately, with no pulse.
  - After release, 8'h01 transmits a full, correct frame.
- CLKS_PER_BIT=1 with 8'h80: tx_out reads 0,1,0,0,0,0,0,0,0,1 on consecutive cycles, and done fires at E0+10.

Source files
------------

// File: rtl/mux_serializer_pkg.sv
// Shared definitions for the mux_serializer frame transmitter: state encodings,
// frame constants and the parity helper.
package mux_serializer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

   localparam int   DATA_BITS  = 8;
   localparam logic STOP_LEVEL = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   // Even parity is the XOR of the byte; odd parity is its complement.
   function automatic logic parity_bit(input logic [7:0] b, input logic odd);
      return (^b) ^ odd;
   endfunction

endpackage

// File: rtl/mux_serializer_eightbitmux.sv
// 8:1 bit selector; select k picks in[7-k] so an incrementing select walks MSB-first.
module eightbitmux
   import mux_serializer_pkg::*;
(
   input  logic [DATA_BITS-1:0] in,
   input  logic [2:0]           s,
   output logic                 out
);

   localparam logic [2:0] TOP_SEL = 3'(DATA_BITS - 1);

   logic [2:0] w_idx;

   assign w_idx = TOP_SEL - s;
   assign out   = in[w_idx];

endmodule

// File: rtl/mux_serializer.sv
// Frame transmitter: start bit, 8 data bits MSB-first through eightbitmux,
// optional parity, stop bit; each bit held CLKS_PER_BIT clocks on a registered line.
module mux_serializer
   import mux_serializer_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] load_data,
   input  logic       load_valid,
   output logic       load_ready,
   output logic       tx_out,
   output logic       busy,
   output logic       done,
   output logic [2:0] dbg_state
);

   // Handshake: a byte is taken on any rising edge where load_valid && load_ready;
   // load_ready is high only in IDLE, so nothing is accepted or queued mid-frame.

   localparam logic [7:0] DIV_LAST = 8'(CLKS_PER_BIT - 1);
   localparam logic [3:0] CNT_LAST = 4'(DATA_BITS);

   state_e     r_state;
   logic [7:0] r_byte;
   logic [3:0] r_bit_cnt;
   logic [7:0] r_div;
   logic       r_tx;
   logic       r_done;

   logic       w_mux_bit;
   logic       w_bit_end;

   eightbitmux u_mux (
      .in  (r_byte),
      .s   (r_bit_cnt[2:0]),
      .out (w_mux_bit)
   );

   assign w_bit_end = (r_div == DIV_LAST);

   // r_bit_cnt holds the index of the next data bit to launch; it reaches 8
   // while the last data bit is on the line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_byte    <= 8'd0;
         r_bit_cnt <= 4'd0;
         r_div     <= 8'd0;
         r_tx      <= IDLE_LEVEL;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state != ST_IDLE) begin
            r_div <= w_bit_end ? 8'd0 : r_div + 8'd1;
         end
         case (r_state)
            ST_IDLE: begin
               if (load_valid) begin
                  r_byte    <= load_data;
                  r_state   <= ST_START;
                  r_tx      <= START_LEVEL;
                  r_div     <= 8'd0;
                  r_bit_cnt <= 4'd0;
               end
            end
            ST_START: begin
               if (w_bit_end) begin
                  r_state   <= ST_DATA;
                  r_tx      <= w_mux_bit;
                  r_bit_cnt <= 4'd1;
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  if (r_bit_cnt == CNT_LAST) begin
                     if (PARITY_EN != 0) begin
                        r_state <= ST_PARITY;
                        r_tx    <= parity_bit(r_byte, PARITY_ODD != 0);
                     end else begin
                        r_state <= ST_STOP;
                        r_tx    <= STOP_LEVEL;
                     end
                  end else begin
                     r_tx      <= w_mux_bit;
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end
            end
            ST_PARITY: begin
               if (w_bit_end) begin
                  r_state <= ST_STOP;
                  r_tx    <= STOP_LEVEL;
               end
            end
            ST_STOP: begin
               if (w_bit_end) begin
                  r_state   <= ST_IDLE;
                  r_tx      <= IDLE_LEVEL;
                  r_done    <= 1'b1;
                  r_bit_cnt <= 4'd0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_tx    <= IDLE_LEVEL;
            end
         endcase
      end
   end

   assign load_ready = (r_state == ST_IDLE);
   assign busy       = (r_state != ST_IDLE);
   assign tx_out     = r_tx;
   assign done       = r_done;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_mux_serializer.sv
// Bench for mux_serializer: four instances (plain, even parity, odd parity,
// one clock per bit) driven by directed and random bytes, checked per cycle.
module tb_mux_serializer;

   localparam int NDUT = 4;
   localparam int CPB  [NDUT] = '{4, 4, 4, 1};
   localparam int PEN  [NDUT] = '{0, 1, 1, 0};
   localparam int PODD [NDUT] = '{0, 0, 1, 0};

   logic       clk;
   logic       rst;
   logic [7:0] load_data  [NDUT];
   logic       load_valid [NDUT];
   wire        load_ready [NDUT];
   wire        tx_out     [NDUT];
   wire        busy       [NDUT];
   wire        done       [NDUT];
   wire  [2:0] dbg_state  [NDUT];

   logic [10:0] exp_q [NDUT][$];

   int n_tests = 0;
   int n_fail  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int d, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d t=%0t got %0h expected %0h", name, d, $time, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input int d);
      n_tests++;
      n_fail++;
      $display("FAIL %s dut%0d t=%0t", name, d, $time);
   endtask

   // Reference frame, bits listed in transmit order (index 0 = start bit).
   function automatic logic [10:0] model_frame(input logic [7:0] b, input int pen,
                                               input int podd);
      logic [10:0] fr;
      int          ones;
      fr    = '1;
      fr[0] = 1'b0;
      for (int k = 0; k < 8; k++) fr[1 + k] = b[7 - k];
      ones = $countones(b);
      if (pen != 0) fr[9] = ((ones % 2) == 1) ? (podd == 0) : (podd != 0);
      return fr;
   endfunction

   generate
      for (genvar g = 0; g < NDUT; g++) begin : g_dut
         mux_serializer #(
            .CLKS_PER_BIT (CPB[g]),
            .PARITY_EN    (PEN[g]),
            .PARITY_ODD   (PODD[g])
         ) u_dut (
            .clk        (clk),
            .reset      (rst),
            .load_data  (load_data[g]),
            .load_valid (load_valid[g]),
            .load_ready (load_ready[g]),
            .tx_out     (tx_out[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .dbg_state  (dbg_state[g])
         );

         // Monitor: a busy rise marks frame cycle 0; check every cycle of the frame.
         initial begin : mon
            logic        prev_busy;
            logic [10:0] fr;
            int          len;
            bit          aborted;
            prev_busy = 1'b0;
            forever begin
               @(negedge clk);
               if (rst) begin
                  prev_busy = 1'b0;
               end else if (busy[g] && !prev_busy) begin
                  if (exp_q[g].size() == 0) begin
                     fail_now("unexpected_frame", g);
                     fr = '1;
                  end else begin
                     fr = exp_q[g].pop_front();
                  end
                  len     = (10 + PEN[g]) * CPB[g];
                  aborted = 1'b0;
                  for (int c = 0; c < len; c++) begin
                     if (c > 0) @(negedge clk);
                     if (rst) begin
                        aborted = 1'b1;
                        break;
                     end
                     check("tx_bit", g, 32'(tx_out[g]), 32'(fr[c / CPB[g]]));
                     check("busy_in_frame", g, 32'(busy[g]), 32'd1);
                     check("ready_in_frame", g, 32'(load_ready[g]), 32'd0);
                     check("done_in_frame", g, 32'(done[g]), 32'd0);
                  end
                  if (!aborted) begin
                     @(negedge clk);
                     if (!rst) begin
                        check("done_at_end", g, 32'(done[g]), 32'd1);
                        check("busy_at_end", g, 32'(busy[g]), 32'd0);
                        check("ready_at_end", g, 32'(load_ready[g]), 32'd1);
                        check("tx_at_end", g, 32'(tx_out[g]), 32'd1);
                     end
                  end
                  prev_busy = 1'b0;
               end else begin
                  check("done_idle", g, 32'(done[g]), 32'd0);
                  prev_busy = busy[g];
               end
            end
         end
      end
   endgenerate

   // Call at a falling edge; returns at the falling edge after acceptance.
   task automatic send(input int d, input logic [7:0] b, input bit hold, output time t_acc);
      int waited;
      load_data[d]  = b;
      load_valid[d] = 1'b1;
      waited        = 0;
      t_acc         = 0;
      while (!load_ready[d]) begin
         @(negedge clk);
         waited++;
         if (waited > 500) begin
            fail_now("accept_timeout", d);
            load_valid[d] = 1'b0;
            return;
         end
      end
      @(posedge clk);
      t_acc = $time;
      exp_q[d].push_back(model_frame(b, PEN[d], PODD[d]));
      @(negedge clk);
      if (!hold) load_valid[d] = 1'b0;
      load_data[d] = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_idle(input int d);
      int n;
      n = 0;
      while (busy[d] && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (busy[d]) fail_now("idle_timeout", d);
   endtask

   task automatic rand_burst(input int d);
      time  t;
      bit   hold;
      logic [7:0] b;
      for (int i = 0; i < 12; i++) begin
         b    = 8'($urandom_range(0, 255));
         hold = (i < 11) && ($urandom_range(0, 1) == 1);
         send(d, b, hold, t);
         if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle(d);
   endtask

   initial begin
      time t0, t1;
      rst = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
         load_valid[d] = 1'b0;
         load_data[d]  = 8'd0;
      end
      #1;
      for (int d = 0; d < NDUT; d++) begin
         check("rst_tx", d, 32'(tx_out[d]), 32'd1);
         check("rst_ready", d, 32'(load_ready[d]), 32'd1);
         check("rst_busy", d, 32'(busy[d]), 32'd0);
         check("rst_done", d, 32'(done[d]), 32'd0);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Basic frame and parity variants.
      send(0, 8'hA5, 1'b0, t0);
      wait_idle(0);
      send(1, 8'hA5, 1'b0, t0);
      send(2, 8'hA5, 1'b0, t1);
      wait_idle(1);
      wait_idle(2);

      // Back-to-back with load_valid held.
      send(0, 8'h3C, 1'b1, t0);
      send(0, 8'hC3, 1'b0, t1);
      check("b2b_gap", 0, 32'((t1 - t0) / 10), 32'd41);
      wait_idle(0);

      // A byte offered mid-frame must be ignored.
      send(0, 8'hFF, 1'b0, t0);
      repeat (8) @(negedge clk);
      load_data[0]  = 8'h00;
      load_valid[0] = 1'b1;
      check("ready_while_busy", 0, 32'(load_ready[0]), 32'd0);
      @(negedge clk);
      load_valid[0] = 1'b0;
      wait_idle(0);
      repeat (4) @(negedge clk);
      check("no_second_frame", 0, 32'(busy[0]), 32'd0);

      // Reset between edges mid-frame, while tx_out is low.
      send(0, 8'hE7, 1'b0, t0);
      repeat (17) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_tx", 0, 32'(tx_out[0]), 32'd1);
      check("midrst_busy", 0, 32'(busy[0]), 32'd0);
      check("midrst_ready", 0, 32'(load_ready[0]), 32'd1);
      check("midrst_done", 0, 32'(done[0]), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(0, 8'h01, 1'b0, t0);
      wait_idle(0);

      // One clock per bit.
      send(3, 8'h80, 1'b0, t0);
      wait_idle(3);

      // Random traffic on every instance at once.
      fork
         rand_burst(0);
         rand_burst(1);
         rand_burst(2);
         rand_burst(3);
      join
      repeat (3) @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         check("queue_empty", d, 32'(exp_q[d].size()), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
